vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 SHALL have parameter H_AREA, default 800, active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 40/128/88, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_AREA, default 600, active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 1/4/23, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 1 each, giving the active level of each sync.
REQ-006 SHALL have parameter SCALE_LOG2, default 2, setting the pixel replication factor S=2^SCALE_LOG2 in both axes.
REQ-007 SHALL have parameter PIPE_LAT, default 1, range 0..4, frame-buffer read latency in cycles.
REQ-008 SHALL have parameter PIX_W, default 1, pixel data width.
REQ-009 SHALL have parameter FC_W, default 8, frame counter width.
REQ-010 CLK_40  input  1  pixel clock; the only clock.
REQ-011 reset_n  input  1  asynchronous, active-low reset.
REQ-012 clk_en  input  1  pixel advance enable.
REQ-013 pixel_in  input  PIX_W  frame-buffer read data.
REQ-014 rd_addr  output  ADDR_W  buffer word address; ADDR_W=clog2((H_AREA/S)*(V_AREA/S)).
REQ-015 rd_en  output  1  read strobe.
REQ-016 hsync, vsync  output  1 each  sync outputs.
REQ-017 blank_n  output  1  low outside the active area.
REQ-018 pixel_out  output  PIX_W  video data.
REQ-019 line_start, frame_start  output  1 each  single-cycle strobes.
REQ-020 frame_count  output  FC_W  completed-frame counter.

Function
REQ-021 SHALL keep counters x in 0..HT-1 and y in 0..VT-1 (HT=H_AREA+H_FP+H_SYNC+H_BP, VT likewise); x advances on each clk_en cycle; on x wrap, y advances; on y wrap, both return to 0.
REQ-022 Region order SHALL be active, front porch, sync, back porch on both axes.
REQ-023 Horizontal sync SHALL be active for x in [H_AREA+H_FP, H_AREA+H_FP+H_SYNC-1]; vertical sync for full lines y in [V_AREA+V_FP, V_AREA+V_FP+V_SYNC-1].
REQ-024 Stage 1, registered one enabled cycle after counter position (x,y), SHALL drive rd_en, rd_addr, line_start (x==0) and frame_start (x==0,y==0).
REQ-025 rd_en SHALL be 1 only for x<H_AREA and y<V_AREA.
REQ-026 rd_addr SHALL equal (y>>SCALE_LOG2)*(H_AREA/S)+(x>>SCALE_LOG2), computed incrementally with no multiplier.
REQ-027 Address tracking: increment every S active pixels; at line end, rewind to row base unless (y mod S)==S-1, then row base += H_AREA/S; at frame wrap, return to 0.
REQ-028 rd_addr SHALL hold its value while rd_en is 0.
REQ-029 hsync, vsync, blank_n and pixel_out for position (x,y) SHALL appear exactly PIPE_LAT+2 enabled cycles after the counter is at (x,y).
REQ-030 pixel_out SHALL be pixel_in, registered, when blank_n is 1; otherwise 0.
REQ-031 frame_count SHALL increment modulo 2^FC_W in the cycle frame_start is high.
REQ-032 While clk_en is 0, counters, address logic, the delay pipeline, strobes and all outputs SHALL hold.
REQ-033 Elaboration SHALL fail if H_AREA or V_AREA is not divisible by S, if PIPE_LAT>4, or if any porch or sync parameter is 0.

Reset
REQ-034 On reset_n low, the block SHALL reset immediately, including mid-line or mid-frame.
REQ-035 Reset values SHALL be: x=y=0, rd_addr=0, row base 0, rd_en=0, blank_n=0, pixel_out=0, hsync=~HS_POL, vsync=~VS_POL, line_start=frame_start=0, frame_count=0, pipeline registers cleared.
REQ-036 The first enabled edge after release SHALL register position (0,0) into stage 1.

Structure
REQ-037 Package vga_pkg SHALL hold the 640x480 and 800x600 timing presets as constants, a timing-parameter struct typedef and the width-derivation functions.
REQ-038 Alignment SHALL use one sub-module, vga_delay_line, a parametrised depth/width shift register with clock enable and async clear.

Verification (small config: H 8/2/2/2, V 4/1/1/1, SCALE_LOG2=1, PIPE_LAT=1, HT=14, VT=7)
REQ-039 Reset release, clk_en=1 -> rd_addr over line 0 = 0,0,1,1,2,2,3,3; line 1 repeats 0..3; lines 2-3 = 4..7; frame length = 98 cycles.
REQ-040 Sync check -> hsync high (HS_POL=1) for x=10..11 each line; vsync high for all of line y=5; blank_n low for x>=8 or y>=4.
REQ-041 Echo buffer (pixel_in = rd_addr[0], 1-cycle latency) -> pixel_out pattern appears 3 cycles after the counter; 0 during blanking.
REQ-042 clk_en low for 5 cycles mid-line at x=3 -> all outputs frozen; sequence resumes with no lost or duplicated pixel.
REQ-043 Assert reset_n low at x=5, y=2 -> outputs take reset values asynchronously; after release, the frame restarts at rd_addr 0 with frame_count=0.
REQ-044 Run 257 frames with FC_W=8 -> frame_count wraps 255->0; frame_start fires once per frame, coincident with line_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing presets, timing struct types and width helpers for the
// scan engine and its testbench.
package vga_pkg;

  typedef struct packed {
    int area;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h: '{area: 32'd640, fp: 32'd16, sync: 32'd96,  bp: 32'd48},
    v: '{area: 32'd480, fp: 32'd10, sync: 32'd2,   bp: 32'd33}
  };

  localparam vga_timing_t VGA_800X600 = '{
    h: '{area: 32'd800, fp: 32'd40, sync: 32'd128, bp: 32'd88},
    v: '{area: 32'd600, fp: 32'd1,  sync: 32'd4,   bp: 32'd23}
  };

  function automatic int axis_total(input int area, input int fp, input int sync, input int bp);
    return area + fp + sync + bp;
  endfunction

  // Never returns 0 so degenerate configurations still yield legal vectors.
  function automatic int width_of(input int n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic int addr_width(input int h_area, input int v_area, input int scale_log2);
    return width_of((h_area >> scale_log2) * (v_area >> scale_log2));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with asynchronous clear, used to align the
// timing flags with the frame-buffer read latency.
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift one place per enabled cycle, otherwise hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// VGA raster scan engine: position counters, scaled frame-buffer addressing,
// and sync/blank/pixel outputs aligned to the buffer read latency.
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int H_AREA     = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_AREA     = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int SCALE_LOG2 = 2,
  parameter int PIPE_LAT   = 1,
  parameter int PIX_W      = 1,
  parameter int FC_W       = 8
) (
  input  logic                                                  CLK_40,
  input  logic                                                  reset_n,
  input  logic                                                  clk_en,
  input  logic [PIX_W-1:0]                                      pixel_in,
  output logic [addr_width(H_AREA, V_AREA, SCALE_LOG2)-1:0]     rd_addr,
  output logic                                                  rd_en,
  output logic                                                  hsync,
  output logic                                                  vsync,
  output logic                                                  blank_n,
  output logic [PIX_W-1:0]                                      pixel_out,
  output logic                                                  line_start,
  output logic                                                  frame_start,
  output logic [FC_W-1:0]                                       frame_count
);

  localparam int S       = 1 << SCALE_LOG2;
  localparam int HT      = axis_total(H_AREA, H_FP, H_SYNC, H_BP);
  localparam int VT      = axis_total(V_AREA, V_FP, V_SYNC, V_BP);
  localparam int X_W     = width_of(HT);
  localparam int Y_W     = width_of(VT);
  localparam int ADDR_W  = addr_width(H_AREA, V_AREA, SCALE_LOG2);
  localparam int H_WORDS = H_AREA / S;

  localparam logic [X_W-1:0] X_LAST     = X_W'(HT - 1);
  localparam logic [X_W-1:0] X_ACT_END  = X_W'(H_AREA);
  localparam logic [X_W-1:0] X_LAST_ACT = X_W'(H_AREA - 1);
  localparam logic [X_W-1:0] X_HS_BEG   = X_W'(H_AREA + H_FP);
  localparam logic [X_W-1:0] X_HS_END   = X_W'(H_AREA + H_FP + H_SYNC);
  localparam logic [X_W-1:0] X_MASK     = X_W'(S - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(VT - 1);
  localparam logic [Y_W-1:0] Y_ACT_END  = Y_W'(V_AREA);
  localparam logic [Y_W-1:0] Y_LAST_ACT = Y_W'(V_AREA - 1);
  localparam logic [Y_W-1:0] Y_VS_BEG   = Y_W'(V_AREA + V_FP);
  localparam logic [Y_W-1:0] Y_VS_END   = Y_W'(V_AREA + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] Y_MASK     = Y_W'(S - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_WORDS);

  if ((H_AREA % S) != 0 || (V_AREA % S) != 0 || PIPE_LAT < 0 || PIPE_LAT > 4 ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
    $error("vga_scan_engine: illegal timing, scale or latency parameters");
  end

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_cur_q, addr_cur_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              started_q, started_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [FC_W-1:0]   frame_count_q, frame_count_d;
  logic [2:0]        s1_flags_q, s1_flags_d;
  logic [2:0]        dly_flags;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              blank_n_q, blank_n_d;
  logic [PIX_W-1:0]  pixel_out_q, pixel_out_d;

  logic h_act, v_act, hs_act, vs_act;

  assign h_act  = (x_q < X_ACT_END);
  assign v_act  = (y_q < Y_ACT_END);
  assign hs_act = (x_q >= X_HS_BEG) && (x_q < X_HS_END);
  assign vs_act = (y_q >= Y_VS_BEG) && (y_q < Y_VS_END);

  // addr_cur tracks the word address of the current (x,y) without a multiplier.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    addr_cur_d = addr_cur_q;
    row_base_d = row_base_q;
    if (clk_en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d        = '0;
          addr_cur_d = '0;
          row_base_d = '0;
        end else if ((y_q < Y_LAST_ACT) && ((y_q & Y_MASK) == Y_MASK)) begin
          y_d        = y_q + Y_W'(1);
          row_base_d = row_base_q + ROW_STEP;
          addr_cur_d = row_base_q + ROW_STEP;
        end else begin
          y_d        = y_q + Y_W'(1);
          addr_cur_d = row_base_q;
        end
      end else begin
        x_d = x_q + X_W'(1);
        if (h_act && v_act && (x_q != X_LAST_ACT) && ((x_q & X_MASK) == X_MASK)) begin
          addr_cur_d = addr_cur_q + ADDR_W'(1);
        end else begin
          addr_cur_d = addr_cur_q;
        end
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Stage 1: read request, strobes, frame counter and raw timing flags.
  always_comb begin
    rd_en_d       = rd_en_q;
    rd_addr_d     = rd_addr_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_count_d = frame_count_q;
    s1_flags_d    = s1_flags_q;
    started_d     = started_q;
    if (clk_en) begin
      rd_en_d       = h_act && v_act;
      rd_addr_d     = (h_act && v_act) ? addr_cur_q : rd_addr_q;
      line_start_d  = (x_q == '0);
      frame_start_d = (x_q == '0) && (y_q == '0);
      s1_flags_d    = {h_act && v_act, hs_act, vs_act};
      started_d     = 1'b1;
      // The first frame start after reset has no completed frame behind it.
      if (frame_start_d && started_q) begin
        frame_count_d = frame_count_q + FC_W'(1);
      end else begin
        frame_count_d = frame_count_q;
      end
    end else begin
      rd_en_d = rd_en_q;
    end
  end

  if (PIPE_LAT > 0) begin : g_delay
    vga_delay_line #(
      .DEPTH (PIPE_LAT),
      .WIDTH (3)
    ) u_delay (
      .clk   (CLK_40),
      .rst_n (reset_n),
      .en    (clk_en),
      .din   (s1_flags_q),
      .dout  (dly_flags)
    );
  end else begin : g_no_delay
    assign dly_flags = s1_flags_q;
  end

  // Output stage: polarity, blanking and pixel capture.
  always_comb begin
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    blank_n_d   = blank_n_q;
    pixel_out_d = pixel_out_q;
    if (clk_en) begin
      blank_n_d   = dly_flags[2];
      hsync_d     = dly_flags[1] ? HS_POL : ~HS_POL;
      vsync_d     = dly_flags[0] ? VS_POL : ~VS_POL;
      pixel_out_d = dly_flags[2] ? pixel_in : '0;
    end else begin
      blank_n_d = blank_n_q;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      addr_cur_q    <= '0;
      row_base_q    <= '0;
      started_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      s1_flags_q    <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_n_q     <= 1'b0;
      pixel_out_q   <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      addr_cur_q    <= addr_cur_d;
      row_base_q    <= row_base_d;
      started_q     <= started_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      s1_flags_q    <= s1_flags_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      pixel_out_q   <= pixel_out_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign rd_en       = rd_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign pixel_out   = pixel_out_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Randomised clock-enable bench for vga_scan_engine in the small 8x4 (x2 scale)
// configuration, checked every cycle against a position-index reference model.
module tb_vga_scan_engine;

  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int FT  = HT * VT;
  localparam int LAT = 3;
  localparam int MAX_TICKS = 90000;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       clk_en   = 1'b0;
  logic       pixel_in;
  logic [2:0] rd_addr;
  logic       rd_en, hsync, vsync, blank_n, pixel_out, line_start, frame_start;
  logic [7:0] frame_count;

  int k         = 0;
  int last_addr = 0;
  int ticks     = 0;
  int n_vec     = 0;
  int n_err     = 0;

  vga_scan_engine #(
    .H_AREA(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_AREA(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .SCALE_LOG2(1), .PIPE_LAT(1), .PIX_W(1), .FC_W(8)
  ) dut (
    .CLK_40(clk), .reset_n(rst_n), .clk_en(clk_en), .pixel_in(pixel_in),
    .rd_addr(rd_addr), .rd_en(rd_en), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .pixel_out(pixel_out), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Echo frame buffer: one enabled cycle of read latency, data = address bit 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_in <= 1'b0;
    else if (clk_en) pixel_in <= rd_addr[0];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got %0d, expected %0d", tag, k, obs, exp);
    end
  endtask

  function automatic int px(input int i); return i % HT; endfunction
  function automatic int py(input int i); return (i / HT) % VT; endfunction
  function automatic bit active(input int i); return px(i) < 8 && py(i) < 4; endfunction
  function automatic int addr_of(input int i); return (py(i) / 2) * 4 + px(i) / 2; endfunction

  // k = enabled edges since reset; stage 1 shows index k-1, outputs index k-LAT.
  task automatic check_all();
    int i, j;
    if (k == 0) begin
      chk("rd_en", rd_en, 0);
      chk("rd_addr", rd_addr, 0);
      chk("line_start", line_start, 0);
      chk("frame_start", frame_start, 0);
      chk("frame_count", frame_count, 0);
    end else begin
      i = k - 1;
      chk("rd_en", rd_en, active(i));
      chk("rd_addr", rd_addr, last_addr);
      chk("line_start", line_start, px(i) == 0);
      chk("frame_start", frame_start, px(i) == 0 && py(i) == 0);
      chk("frame_count", frame_count, (i / FT) % 256);
    end
    if (k < LAT) begin
      chk("hsync", hsync, 0);
      chk("vsync", vsync, 0);
      chk("blank_n", blank_n, 0);
      chk("pixel_out", pixel_out, 0);
    end else begin
      j = k - LAT;
      chk("hsync", hsync, px(j) >= 10 && px(j) <= 11);
      chk("vsync", vsync, py(j) == 5);
      chk("blank_n", blank_n, active(j));
      chk("pixel_out", pixel_out, active(j) ? (addr_of(j) & 1) : 0);
    end
  endtask

  task automatic tick(input bit en);
    clk_en = en;
    @(posedge clk);
    ticks++;
    if (en) begin
      k++;
      if (active(k - 1)) last_addr = addr_of(k - 1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    k = 0;
    last_addr = 0;
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // One full frame with the enable held high.
    for (int n = 0; n < FT; n++) tick(1'b1);

    // Stall five cycles with the counter parked at x=3.
    while (k % HT != 3 && ticks < MAX_TICKS) tick(1'b1);
    for (int n = 0; n < 5; n++) tick(1'b0);
    for (int n = 0; n < 2 * HT; n++) tick(1'b1);

    // Random enable, then reset with the counter at x=5, y=2.
    for (int n = 0; n < 300; n++) tick($urandom_range(0, 3) != 0);
    while (k % FT != 2 * HT + 5 && ticks < MAX_TICKS) tick($urandom_range(0, 3) != 0);
    @(negedge clk);
    do_reset();
    for (int n = 0; n < 4; n++) tick(1'b1);

    // Long random run through the frame counter wrap.
    while (k < 257 * FT + 20 && ticks < MAX_TICKS) tick($urandom_range(0, 3) != 0);
    chk("run_budget", (k >= 257 * FT + 20) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
